// File: rtl/data_read_pkg.sv
// Shared definitions for the data_read path: register map, capture state
// encoding and the AXI address decode of the capture buffer regions.
package data_read_pkg;

  localparam logic [31:0] AXI_ADDR_CR  = 32'h0000_0000;
  localparam logic [31:0] AXI_ADDR_SR  = 32'h0000_0004;
  localparam int          CR_START_BIT = 0;
  localparam int          SR_C_BIT     = 0;
  localparam int          NBUF         = 4;
  localparam int          BUF_ADDR_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  // Buffer n is mapped at ARADDR[12:10] = n + 1; region 0 holds CR/SR.
  function automatic logic araddr_is_buf(input logic [12:0] araddr);
    return (araddr[12:10] >= 3'd1) && (araddr[12:10] <= 3'(NBUF));
  endfunction

  function automatic logic [1:0] araddr_buf_sel(input logic [12:0] araddr);
    logic [2:0] region;
    region = araddr[12:10] - 3'd1;
    return region[1:0];
  endfunction

endpackage

// File: rtl/data_read_buf_ram.sv
// Simple dual-port capture RAM addressed as {sel, addr}; one write port and
// one registered read-first read port whose output register resets to zero.
module data_read_buf_ram #(
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  rsel,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** (SEL_W + ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[{wsel, waddr}] <= wdata;
  end

  always_comb begin
    rdata_d = mem[{rsel, raddr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_read_capture.sv
// Packs the 8-bit sample stream into 32-bit words and fills four capture
// buffers in sequence, raising sr_c once the last word has landed.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for start, samples ignored
// ST_CAPTURE | packing samples and writing words, busy = 1
// ST_DONE    | all buffers full, sr_c = 1, samples ignored
module data_read_capture #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 10,
  parameter int NBUF     = 4
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    start,
  input  logic [SAMPLE_W-1:0]     din,
  input  logic                    din_valid,
  output logic                    sr_c,
  output logic                    busy,
  input  logic [$clog2(NBUF)-1:0] buf_sel,
  input  logic [ADDR_W-1:0]       buf_addr,
  output logic [4*SAMPLE_W-1:0]   buf_data
);

  import data_read_pkg::*;

  localparam int SEL_W  = $clog2(NBUF);
  localparam int PTR_W  = SEL_W + ADDR_W;
  localparam int WORD_W = 4 * SAMPLE_W;
  localparam int PACK_W = 3 * SAMPLE_W;

  cap_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic              last_q, last_d;
  logic              sr_c_q, sr_c_d;
  logic              busy_q, busy_d;
  logic              we;
  logic [WORD_W-1:0] wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    last_d  = last_q;
    sr_c_d  = sr_c_q;
    busy_d  = busy_q;
    we      = 1'b0;
    wdata   = {din, pack_q};

    if (start) begin
      state_d = ST_CAPTURE;
      ptr_d   = '0;
      cnt_d   = '0;
      pack_d  = '0;
      last_d  = 1'b0;
      sr_c_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          // last_q marks the cycle after the final write; the pointer is
          // held rather than wrapped and any sample here is dropped.
          if (last_q) begin
            state_d = ST_DONE;
            last_d  = 1'b0;
            sr_c_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (din_valid) begin
            if (cnt_q == 2'd3) begin
              we     = 1'b1;
              cnt_d  = '0;
              pack_d = '0;
              if (ptr_q == '1) last_d = 1'b1;
              else             ptr_d  = ptr_q + 1'b1;
            end else begin
              cnt_d  = cnt_q + 2'd1;
              pack_d = {din, pack_q[PACK_W-1:SAMPLE_W]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      last_q  <= 1'b0;
      sr_c_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      last_q  <= last_d;
      sr_c_q  <= sr_c_d;
      busy_q  <= busy_d;
    end
  end

  assign sr_c = sr_c_q;
  assign busy = busy_q;

  data_read_buf_ram #(
    .SEL_W  (SEL_W),
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .we    (we),
    .wsel  (ptr_q[PTR_W-1 -: SEL_W]),
    .waddr (ptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .rsel  (buf_sel),
    .raddr (buf_addr),
    .rdata (buf_data)
  );

endmodule

// File: tb/tb_data_read_capture.sv
// Directed bench for data_read_capture; buffer reads are checked by a
// scoreboard queue popped by an independent monitor one edge after issue.
`timescale 1ns/1ps
module tb_data_read_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        sr_c;
  logic        busy;
  logic [1:0]  buf_sel = 2'd0;
  logic [9:0]  buf_addr = 10'd0;
  logic [31:0] buf_data;

  logic        rd_req = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  data_read_capture dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start         (start),
    .din           (din),
    .din_valid     (din_valid),
    .sr_c          (sr_c),
    .busy          (busy),
    .buf_sel       (buf_sel),
    .buf_addr      (buf_addr),
    .buf_data      (buf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: any edge that sampled a read request must present the
  // oldest queued expectation on buf_data just after that edge.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      if (rd_req) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got 0x%08h, expected no read", buf_data);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, buf_data, e);
        end
      end
    end
  end

  task automatic sample(input logic [7:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic v, input logic [7:0] d);
    start     = 1'b1;
    din_valid = v;
    din       = d;
    @(negedge clk);
    start     = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] sel, input logic [9:0] addr,
                    input logic [31:0] exp);
    din_valid = 1'b0;
    buf_sel   = sel;
    buf_addr  = addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;

    // Reset state
    #12;
    check("reset_sr_c", 32'(sr_c), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_buf_data", buf_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full capture, din = i[7:0]
    pulse_start(1'b0, 8'h00);
    check("cap1_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 16384; i++) begin
      b = 8'(i);
      sample(b, 1'b1);
    end
    din_valid = 1'b0;
    check("cap1_sr_c_at_last_write", 32'(sr_c), 32'd0);
    check("cap1_busy_at_last_write", 32'(busy), 32'd1);
    @(negedge clk);
    check("cap1_sr_c_after", 32'(sr_c), 32'd1);
    check("cap1_busy_after", 32'(busy), 32'd0);
    rd("cap1_w0_0",    2'd0, 10'd0,    32'h03020100);
    rd("cap1_w0_1",    2'd0, 10'd1,    32'h07060504);
    rd("cap1_w1_0",    2'd1, 10'd0,    32'h03020100);
    rd("cap1_w2_5",    2'd2, 10'd5,    32'h17161514);
    rd("cap1_w3_1023", 2'd3, 10'd1023, 32'hFFFEFDFC);

    // Samples in DONE are dropped
    for (int i = 0; i < 8; i++) sample(8'h55, 1'b1);
    din_valid = 1'b0;
    check("done_sr_c_held", 32'(sr_c), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    rd("done_w3_1023", 2'd3, 10'd1023, 32'hFFFEFDFC);

    // Second capture, din = ~i[7:0], with same-cycle read/write at {2,5}
    pulse_start(1'b0, 8'h00);
    check("cap2_sr_c_cleared", 32'(sr_c), 32'd0);
    for (int i = 0; i < 16384; i++) begin
      b = ~8'(i);
      if (i == 8215 || i == 8216) begin
        buf_sel  = 2'd2;
        buf_addr = 10'd5;
        exp_q.push_back(i == 8215 ? 32'h17161514 : 32'hE8E9EAEB);
        name_q.push_back(i == 8215 ? "rw_same_cycle_old" : "rw_next_new");
        rd_req = 1'b1;
      end else begin
        rd_req = 1'b0;
      end
      sample(b, 1'b1);
    end
    rd_req    = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    check("cap2_sr_c", 32'(sr_c), 32'd1);
    rd("cap2_w3_1023", 2'd3, 10'd1023, 32'h00010203);

    // Gapped valid
    pulse_start(1'b0, 8'h00);
    check("gap_sr_c_cleared", 32'(sr_c), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      b = 8'hA0 + 8'(k);
      sample(b, 1'b1);
      sample(8'hEE, 1'b0);
    end
    rd("gap_w0_0", 2'd0, 10'd0, 32'hA3A2A1A0);
    rd("gap_w0_1", 2'd0, 10'd1, 32'hF8F9FAFB);

    // Restart during capture
    pulse_start(1'b0, 8'h00);
    for (int k = 1; k <= 6; k++) sample(8'(k), 1'b1);
    pulse_start(1'b0, 8'h00);
    for (int k = 0; k < 4; k++) sample(8'h11 + 8'(k), 1'b1);
    rd("restart_w0_0", 2'd0, 10'd0, 32'h14131211);
    rd("restart_w0_1", 2'd0, 10'd1, 32'hF8F9FAFB);

    // start coincident with din_valid
    pulse_start(1'b1, 8'h99);
    for (int k = 0; k < 4; k++) sample(8'h21 + 8'(k), 1'b1);
    rd("coincident_w0_0", 2'd0, 10'd0, 32'h24232221);

    // Reset mid-capture
    pulse_start(1'b0, 8'h00);
    for (int i = 0; i < 100; i++) sample(8'(i), 1'b1);
    rd("midcap_w0_1", 2'd0, 10'd1, 32'h07060504);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_sr_c", 32'(sr_c), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_buf_data", buf_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) sample(8'h77, 1'b1);
    din_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    pulse_start(1'b0, 8'h00);
    for (int k = 0; k < 4; k++) sample(8'h41 + 8'(k), 1'b1);
    rd("postreset_w0_0", 2'd0, 10'd0, 32'h44434241);
    rd("postreset_w0_1", 2'd0, 10'd1, 32'h07060504);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
